// File: rtl/regsel_decoder_if.sv
// Bus bundle for the two-port register-select decoder: request inputs,
// port B handshake and the registered write-enable / conflict outputs.
interface regsel_decoder_if #(
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
);
  localparam int N = 2**ADDR_W;

  logic              en;
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic              b_ready;
  logic [N-1:0]      ya;
  logic [N-1:0]      yb;
  logic [CNT_W-1:0]  conflict_cnt;

  modport master (
    output en, a_valid, a_addr, b_valid, b_addr,
    input  b_ready, ya, yb, conflict_cnt
  );

  modport slave (
    input  en, a_valid, a_addr, b_valid, b_addr,
    output b_ready, ya, yb, conflict_cnt
  );
endinterface

// File: rtl/regsel_decoder.sv
// Two-port register-select decoder. Port A has priority and is never
// stalled; a port B request that collides with A on the same register is
// parked in pend_q and issued once A moves off that register.
module regsel_decoder #(
  parameter int ADDR_W  = 3,
  parameter bit ZERO_RO = 1'b0,
  parameter int CNT_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  regsel_decoder_if.slave bus
);
  localparam int N = 2**ADDR_W;

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pend_q,  pend_d;
  logic [N-1:0]      ya_q,    ya_d;
  logic [N-1:0]      yb_q,    yb_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  function automatic logic [N-1:0] onehot(input logic [ADDR_W-1:0] addr);
    logic [N-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

  // Address 0 is a read-only register when ZERO_RO is set: it never gets
  // an enable and can never be the subject of a conflict.
  function automatic logic is_prot(input logic [ADDR_W-1:0] addr);
    return ZERO_RO && (addr == '0);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // B is only accepted while nothing is parked, outside reset, when enabled.
  assign bus.b_ready = bus.en & ~rst & (state_q == IDLE);

  // Next-state and next-output decode; everything defaults to "hold state,
  // issue nothing", which is also the en=0 behaviour.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    ya_d    = '0;
    yb_d    = '0;
    if (bus.en) begin
      if (bus.a_valid && !is_prot(bus.a_addr)) begin
        ya_d = onehot(bus.a_addr);
      end
      case (state_q)
        IDLE: begin
          if (bus.b_valid && bus.b_ready && !is_prot(bus.b_addr)) begin
            if (bus.a_valid && (bus.a_addr == bus.b_addr)) begin
              pend_d  = bus.b_addr;
              state_d = HELD;
              cnt_d   = sat_inc(cnt_q);
            end else begin
              yb_d = onehot(bus.b_addr);
            end
          end
        end
        HELD: begin
          if (bus.a_valid && (bus.a_addr == pend_q)) begin
            cnt_d = sat_inc(cnt_q);
          end else begin
            yb_d    = onehot(pend_q);
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; reset also drops any parked B request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ya_q    <= '0;
      yb_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ya_q    <= ya_d;
      yb_q    <= yb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ya           = ya_q;
  assign bus.yb           = yb_q;
  assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_regsel_decoder.sv
// Bench for regsel_decoder: three instances (default, ZERO_RO=1, CNT_W=2)
// share one stimulus stream; a per-instance reference model predicts what
// each should show every cycle and a monitor compares from a queue.
module tb_regsel_decoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       av  = 1'b0;
  logic       bv  = 1'b0;
  logic [2:0] aa  = '0;
  logic [2:0] ba  = '0;

  logic [7:0] ya_w  [3];
  logic [7:0] yb_w  [3];
  logic [7:0] cnt_w [3];
  logic       br_w  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CW = (g == 2) ? 2 : 8;
    regsel_decoder_if #(.ADDR_W(3), .CNT_W(CW)) u_if ();
    assign u_if.en      = en;
    assign u_if.a_valid = av;
    assign u_if.a_addr  = aa;
    assign u_if.b_valid = bv;
    assign u_if.b_addr  = ba;
    assign ya_w[g]      = u_if.ya;
    assign yb_w[g]      = u_if.yb;
    assign cnt_w[g]     = 8'(u_if.conflict_cnt);
    assign br_w[g]      = u_if.b_ready;
    regsel_decoder #(.ADDR_W(3), .ZERO_RO(g == 1), .CNT_W(CW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
    );
  end

  typedef struct {
    logic [2:0][7:0] ya;
    logic [2:0][7:0] yb;
    logic [2:0][7:0] cnt;
    logic [2:0]      br;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference model: for each instance, what a decoder obeying the
  // register-select rules would currently be presenting.
  int m_ya[3], m_yb[3], m_cnt[3], m_pend[3];
  bit m_held[3];

  function automatic void chk(input string name, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0h expected %0h at %0t", name, inst, act, exp, $time);
    end
  endfunction

  function automatic void model_edge(input int i, input bit r, input bit e, input bit a_v,
                                     input int a_a, input bit b_v, input int b_a);
    bit zro  = (i == 1);
    int cmax = (i == 2) ? 3 : 255;
    if (r) begin
      m_ya[i] = 0; m_yb[i] = 0; m_cnt[i] = 0; m_pend[i] = 0; m_held[i] = 0;
    end else if (!e) begin
      m_ya[i] = 0; m_yb[i] = 0;
    end else begin
      m_ya[i] = (a_v && !(zro && a_a == 0)) ? (1 << a_a) : 0;
      if (m_held[i]) begin
        if (a_v && a_a == m_pend[i]) begin
          m_yb[i]  = 0;
          m_cnt[i] = (m_cnt[i] + 1 > cmax) ? cmax : m_cnt[i] + 1;
        end else begin
          m_yb[i]   = 1 << m_pend[i];
          m_held[i] = 0;
        end
      end else if (b_v) begin
        if (zro && b_a == 0) begin
          m_yb[i] = 0;
        end else if (a_v && a_a == b_a) begin
          m_yb[i]   = 0;
          m_pend[i] = b_a;
          m_held[i] = 1;
          m_cnt[i]  = (m_cnt[i] + 1 > cmax) ? cmax : m_cnt[i] + 1;
        end else begin
          m_yb[i] = 1 << b_a;
        end
      end else begin
        m_yb[i] = 0;
      end
    end
  endfunction

  // One cycle of stimulus: record what each instance should show during
  // this cycle, then advance the model across the coming edge.
  task automatic drive(input bit r, input bit e, input bit a_v, input int a_a,
                       input bit b_v, input int b_a);
    exp_t x;
    @(posedge clk);
    #2;
    rst = r; en = e; av = a_v; aa = 3'(a_a); bv = b_v; ba = 3'(b_a);
    for (int i = 0; i < 3; i++) begin
      x.ya[i]  = 8'(m_ya[i]);
      x.yb[i]  = 8'(m_yb[i]);
      x.cnt[i] = 8'(m_cnt[i]);
      x.br[i]  = e && !r && !m_held[i];
    end
    sb.push_back(x);
    for (int i = 0; i < 3; i++) model_edge(i, r, e, a_v, a_a, b_v, b_a);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 1, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle the DUTs present outputs, compare against the
  // oldest prediction and the structural one-hot / disjointness rules.
  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      for (int i = 0; i < 3; i++) begin
        chk("ya", i, int'(ya_w[i]), int'(x.ya[i]));
        chk("yb", i, int'(yb_w[i]), int'(x.yb[i]));
        chk("conflict_cnt", i, int'(cnt_w[i]), int'(x.cnt[i]));
        chk("b_ready", i, int'(br_w[i]), int'(x.br[i]));
        chk("ya_yb_overlap", i, int'(ya_w[i] & yb_w[i]), 0);
        chk("onehot0", i, int'($onehot0(ya_w[i]) && $onehot0(yb_w[i])), 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_ya[i] = 0; m_yb[i] = 0; m_cnt[i] = 0; m_pend[i] = 0; m_held[i] = 0;
    end
    // reset, with requests present that must be ignored
    drive(1, 1, 1, 5, 1, 5);
    drive(1, 1, 0, 0, 0, 0);
    idle(2);
    // distinct addresses in the same cycle
    drive(0, 1, 1, 5, 1, 2);
    idle(2);
    // single conflict then release
    drive(0, 1, 1, 3, 1, 3);
    idle(3);
    // conflict on 6 held by two more A hits, then A leaves
    drive(0, 1, 1, 6, 1, 6);
    drive(0, 1, 1, 6, 0, 0);
    drive(0, 1, 1, 6, 0, 0);
    drive(0, 1, 1, 1, 0, 0);
    idle(2);
    // address 0 traffic, then B alone on 1
    drive(0, 1, 1, 0, 1, 0);
    drive(0, 1, 0, 0, 1, 1);
    idle(3);
    // reset while a B request is parked on 4
    drive(0, 1, 1, 4, 1, 4);
    drive(1, 1, 1, 4, 1, 4);
    idle(3);
    // five conflicts on 7 to saturate the narrow counter, then en=0
    drive(0, 1, 1, 7, 1, 7);
    for (int k = 0; k < 4; k++) drive(0, 1, 1, 7, 0, 0);
    drive(0, 0, 1, 7, 1, 7);
    drive(0, 1, 1, 7, 0, 0);
    idle(3);
    // randomized traffic, biased towards collisions
    for (int k = 0; k < 600; k++) begin
      int a_a, b_a;
      bit r, e, a_v, b_v;
      r   = ($urandom_range(0, 39) == 0);
      e   = ($urandom_range(0, 99) < 85);
      a_v = ($urandom_range(0, 99) < 70);
      b_v = ($urandom_range(0, 99) < 70);
      a_a = $urandom_range(0, 7);
      b_a = ($urandom_range(0, 1) == 0) ? a_a : $urandom_range(0, 7);
      drive(r, e, a_v, a_a, b_v, b_a);
    end
    idle(2);
    @(negedge clk);
    #1;
    chk("queue_drained", 0, sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
